// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants used by the fetch stage.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low bits of a target are ignored.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small instruction buffer between memory responses and decode.
// Head entry is read combinationally; push into a full FIFO is legal with a same-cycle pop.
module if_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fetch_entry_t mem_reg [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests,
// buffers returned words for decode and discards in-flight words after a redirect.
module if_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Inst,
  output logic [31:0] inst_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_wdata;

  logic [CW:0]   committed;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          rsp_keep;
  logic          inst_pop;

  assign redirect_target = align_word(redirect_pc);

  // Slots already promised: buffered words plus responses that will be kept.
  assign committed = {1'b0, fifo_count} + {1'b0, inflight_reg} - {1'b0, drop_cnt_reg};

  assign imem_req_valid = (state_reg == FETCH) && (committed < DEPTH_W) && !redirect_valid;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response coinciding with a redirect belongs to the old path.
  assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign inst_pop = inst_valid && inst_ready;

  assign fifo_wdata.inst = imem_rsp_data;
  assign fifo_wdata.pc   = rsp_pc_reg;

  always_comb begin
    state_next    = FETCH;
    pc_next       = pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    inflight_next = inflight_reg;
    drop_cnt_next = drop_cnt_reg;

    if (req_fire && !imem_rsp_valid) begin
      inflight_next = inflight_reg + CNT_ONE;
    end else if (!req_fire && imem_rsp_valid) begin
      inflight_next = inflight_reg - CNT_ONE;
    end

    if (redirect_valid) begin
      pc_next       = redirect_target;
      rsp_pc_next   = redirect_target;
      drop_cnt_next = inflight_next;
    end else begin
      if (req_fire) pc_next = pc_reg + PC_STEP;
      if (rsp_keep) rsp_pc_next = rsp_pc_reg + PC_STEP;
      if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (inst_pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign Inst       = fifo_empty ? INST_NOP : fifo_head.inst;
  assign inst_pc    = fifo_empty ? 32'h0000_0000 : fifo_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed sequences, an alignment table
// and a randomized run against a queue-based reference of the fetch contract.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import rv32i_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] Inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .Inst           (Inst),
    .inst_pc        (inst_pc)
  );

  // Reference: each outstanding request remembers the path (epoch) it was issued on;
  // only words from the current path reach decode, in request order, tagged with their address.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } align_vec_t;

  mem_req_t     memq[$];
  fetch_entry_t ref_fifo[$];
  int           epoch = 0;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  ref_req_pc = RESET_PC;
  bit           ref_idle = 1'b1;
  int           lat_min = 1, lat_max = 1, rsp_pct = 100;

  bit           obs_fire, obs_inst_valid;
  logic [31:0]  obs_inst_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int live_outstanding();
    int n = 0;
    foreach (memq[i]) if (memq[i].epoch == epoch) n++;
    return n;
  endfunction

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit irdy);
    bit           rsp, exp_rv, fire, keep, do_pop;
    mem_req_t     r;
    fetch_entry_t e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    rsp = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memq[0].data : $urandom;
    #1;
    exp_rv = !ref_idle && (ref_fifo.size() + live_outstanding() < DEPTH) && !redir;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, ref_req_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, ref_fifo.size() > 0});
    if (ref_fifo.size() > 0) begin
      check("inst", Inst, ref_fifo[0].inst);
      check("inst_pc", inst_pc, ref_fifo[0].pc);
    end else begin
      check("inst_nop", Inst, INST_NOP);
    end
    obs_fire       = imem_req_valid && rdy;
    obs_inst_valid = inst_valid;
    obs_inst_pc    = inst_pc;

    fire   = exp_rv && rdy;
    do_pop = (ref_fifo.size() > 0) && irdy;
    if (do_pop && !redir) $display("cycle %0d decode pc=%h inst=%h", cyc, ref_fifo[0].pc, ref_fifo[0].inst);
    keep = 1'b0;
    if (rsp) begin
      r    = memq.pop_front();
      keep = (r.epoch == epoch) && !redir;
    end
    if (redir) begin
      ref_fifo.delete();
      epoch++;
      ref_req_pc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(ref_fifo.pop_front());
      if (keep) begin
        e.inst = r.data;
        e.pc   = r.addr;
        ref_fifo.push_back(e);
      end
    end
    if (fire) begin
      r.addr  = ref_req_pc;
      r.data  = $urandom;
      r.epoch = epoch;
      r.due   = cyc + int'($urandom_range(lat_max, lat_min));
      memq.push_back(r);
      ref_req_pc = ref_req_pc + 32'd4;
    end
    ref_idle = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset away from any clock edge and checks outputs clear immediately.
  task automatic do_reset();
    #2;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", Inst, INST_NOP);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    memq.delete();
    ref_fifo.delete();
    ref_req_pc = RESET_PC;
    ref_idle   = 1'b1;
    epoch++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs until decode sees a valid word; the required first PC is checked.
  task automatic expect_first_pc(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_inst_valid) begin
        seen = 1'b1;
        check(name, obs_inst_pc, exp_pc);
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    align_vec_t tbl[4];
    int first, nfire;
    tbl[0].rpc = 32'h0000_0103; tbl[0].exp_addr = 32'h0000_0100;
    tbl[1].rpc = 32'h0000_0002; tbl[1].exp_addr = 32'h0000_0000;
    tbl[2].rpc = 32'hFFFF_FFFF; tbl[2].exp_addr = 32'hFFFF_FFFC;
    tbl[3].rpc = 32'h0000_0200; tbl[3].exp_addr = 32'h0000_0200;

    @(negedge clk);
    do_reset();

    // Streaming with ready memory and 1-cycle responses.
    lat_min = 1; lat_max = 1; rsp_pct = 100;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_inst_valid && first < 0) first = i;
    end
    check("first_valid_cycle", first, 32'd4);

    // Decode stalled: credits cap requests at DEPTH.
    do_reset();
    nfire = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_fire) nfire++;
    end
    check("stall_req_count", nfire, DEPTH);
    check("stall_head_pc", inst_pc, 32'h0);
    check("stall_next_addr", imem_req_addr, 32'h8);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two requests in flight.
    do_reset();
    lat_min = 4; lat_max = 4;
    nfire = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_fire) nfire++;
    end
    check("inflight_before_redirect", nfire, 32'd2);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    check("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    lat_min = 1; lat_max = 1;
    expect_first_pc("redirect_100_pc", 32'h100);

    // Redirect coinciding with a response arrival and a ready memory.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    expect_first_pc("redirect_200_pc", 32'h200);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect target alignment table.
    lat_min = 1; lat_max = 2;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, tbl[t].rpc, 1'b0, 1'b1);
      check("align_req_addr", imem_req_addr, tbl[t].exp_addr);
      expect_first_pc("align_inst_pc", tbl[t].exp_addr);
    end

    // Reset with a filled buffer and work outstanding.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("restart_addr", imem_req_addr, RESET_PC);

    // Randomized traffic.
    lat_min = 1; lat_max = 3; rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 2) do_reset();
      step($urandom_range(99) < 4, $urandom, $urandom_range(99) < 75, $urandom_range(99) < 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
